// File: rtl/rng_scroll_pkg.sv
// rtl/rng_scroll_pkg.sv - shared types and constants for the chaos-core RNG scroll controller
package rng_scroll_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEED = 2'd1,
        WARM = 2'd2,
        RUN  = 2'd3
    } state_t;

    localparam int HEALTH_REPEAT  = 8;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_WARM_W     = 16;

endpackage

// File: rtl/rng_scroll_fifo.sv
// rtl/rng_scroll_fifo.sv - synchronous show-ahead FIFO with occupancy count and flush
module rng_scroll_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                   wb_clk_i,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (count != FULL);
    assign do_pop  = pop && (count != '0);
    assign head    = (count != '0) ? mem[rd_ptr] : '0;

    // storage write; contents need no reset because count gates visibility
    always_ff @(posedge wb_clk_i) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // pointers wrap naturally at the power-of-two depth; flush empties in one edge
    always_ff @(posedge wb_clk_i) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rng_scroll_ctrl.sv
// rtl/rng_scroll_ctrl.sv - seed/warm-up/run sequencer for a chaos-core RNG; RNG_SCROLL_CTRL_HEALTH_EN adds a stuck-output detector
import rng_scroll_pkg::*;

module rng_scroll_ctrl #(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int WARM_W     = DEF_WARM_W
) (
    input  logic              wb_clk_i,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              reseed,
    input  logic [WARM_W-1:0] warm_cycles,
    input  logic [31:0]       core_x,
    input  logic [31:0]       core_y,
    input  logic [31:0]       core_z,
    output logic              core_rst,
    output logic              core_step,
    output logic              rnd_valid,
    input  logic              rnd_ready,
    output logic [31:0]       rnd_data,
    output logic              busy,
    output logic [1:0]        state,
    output logic              health_err
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t            state_q;
    state_t            state_d;
    logic [WARM_W-1:0] warm_cnt;
    logic [CW-1:0]     fifo_count;
    logic              step_d;
    logic [31:0]       mix_word;
    logic              health_trip;
    logic              reseed_go;
    logic              flush;

    assign mix_word  = core_x ^ core_y ^ core_z;
    assign reseed_go = (reseed || health_trip) && (state_q != IDLE);
    assign flush     = reseed_go && !stop && !rst;
    assign busy      = (state_q != IDLE);
    assign state     = state_q;
    assign core_rst  = (state_q == SEED) && !rst;
    assign rnd_valid = (fifo_count != '0);

    // next state and step request; stop beats reseed, both cancel stepping at once
    always_comb begin
        state_d   = state_q;
        core_step = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = SEED;
            SEED: state_d = (warm_cycles == '0) ? RUN : WARM;
            WARM: begin
                core_step = 1'b1;
                if (warm_cnt <= WARM_W'(1)) state_d = RUN;
            end
            RUN: core_step = (fifo_count + CW'(step_d)) < CW'(FIFO_DEPTH);
            default: state_d = IDLE;
        endcase
        if (stop) begin
            state_d   = IDLE;
            core_step = 1'b0;
        end else if (reseed_go) begin
            state_d   = SEED;
            core_step = 1'b0;
        end
        if (rst) core_step = 1'b0;
    end

    // state register
    always_ff @(posedge wb_clk_i) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // warm-up counter loads while seeding and saturates at zero
    always_ff @(posedge wb_clk_i) begin
        if (rst) begin
            warm_cnt <= '0;
        end else if (state_q == SEED) begin
            warm_cnt <= warm_cycles;
        end else if (state_q == WARM && warm_cnt != '0) begin
            warm_cnt <= warm_cnt - 1'b1;
        end
    end

    // a RUN step's result is visible on the core one cycle later, so remember it
    always_ff @(posedge wb_clk_i) begin
        if (rst || flush) step_d <= 1'b0;
        else              step_d <= core_step && (state_q == RUN);
    end

    rng_scroll_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (32)
    ) u_fifo (
        .wb_clk_i  (wb_clk_i),
        .rst       (rst),
        .flush     (flush),
        .push      (step_d),
        .push_data (mix_word),
        .pop       (rnd_valid && rnd_ready),
        .head      (rnd_data),
        .count     (fifo_count)
    );

`ifdef RNG_SCROLL_CTRL_HEALTH_EN
    logic [31:0] last_word;
    logic [3:0]  rep_cnt;
    logic        health_q;

    assign health_err = health_q;

    // trip on the push that completes a run of identical words
    always_comb begin
        health_trip = step_d && (rep_cnt == 4'(HEALTH_REPEAT - 1)) && (mix_word == last_word);
    end

    // run-length tracker of pushed words; sticky error flag
    always_ff @(posedge wb_clk_i) begin
        if (rst) begin
            last_word <= '0;
            rep_cnt   <= '0;
            health_q  <= 1'b0;
        end else begin
            if (health_trip) health_q <= 1'b1;
            if (state_q == SEED) begin
                rep_cnt <= '0;
            end else if (step_d) begin
                last_word <= mix_word;
                if (rep_cnt != '0 && mix_word == last_word) begin
                    if (rep_cnt != 4'(HEALTH_REPEAT)) rep_cnt <= rep_cnt + 1'b1;
                end else begin
                    rep_cnt <= 4'd1;
                end
            end
        end
    end
`else
    assign health_trip = 1'b0;
    assign health_err  = 1'b0;
`endif

endmodule

// File: doc/rng_scroll_ctrl.md
RNG_SCROLL_CTRL -- requirements
Module: rng_scroll_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, giving the output FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter WARM_W, default 16, giving the width of the warm-up count.
REQ-003 SHALL have reset rst, synchronous, active-high; clock wb_clk_i.
REQ-004 wb_clk_i  in  1  clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  pulse; begin seeding when IDLE.
REQ-007 stop  in  1  pulse; return to IDLE.
REQ-008 reseed  in  1  pulse; restart from SEED when not IDLE.
REQ-009 warm_cycles  in  WARM_W  core steps discarded after each seed.
REQ-010 core_x, core_y, core_z  in  32 each  registered chaos-core state.
REQ-011 core_rst  out  1  loads the init values into the core.
REQ-012 core_step  out  1  advances the core one iteration.
REQ-013 rnd_valid  out  1 / rnd_ready  in  1 / rnd_data  out  32  output word handshake.
REQ-014 busy  out  1  state != IDLE; state  out  2  IDLE=0, SEED=1, WARM=2, RUN=3.
REQ-015 health_err  out  1  sticky stuck-output flag.

Function
REQ-016 The block SHALL implement FSM IDLE, SEED, WARM and RUN, with the encoding given in REQ-014.
REQ-017 IDLE SHALL go to SEED on start; otherwise it SHALL hold.
REQ-018 SEED SHALL last exactly 1 cycle with core_rst=1, then go to WARM, or to RUN if warm_cycles==0.
REQ-019 WARM SHALL latch warm_cycles on entry, assert core_step every cycle, and go to RUN after exactly warm_cycles steps.
REQ-020 In RUN, core_step SHALL be 1 iff fifo_count + step_d < FIFO_DEPTH, where step_d is core_step registered from the previous RUN cycle.
REQ-021 Every cycle with step_d=1 SHALL push core_x ^ core_y ^ core_z (post-step values) into the FIFO.
REQ-022 The FIFO SHALL never overflow, and no step result SHALL ever be dropped.
REQ-023 rnd_valid SHALL equal (fifo_count != 0), and rnd_data SHALL be the FIFO head.
REQ-024 The FIFO SHALL pop on rnd_valid && rnd_ready.
REQ-025 A simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-026 A pop while full SHALL free a slot for core_step in the following cycle.
REQ-027 The FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 stop SHALL go to IDLE from any state and SHALL deassert core_step the same cycle.
REQ-029 After stop, FIFO contents SHALL be retained and a pending step_d push SHALL still complete.
REQ-030 reseed SHALL go to SEED from SEED, WARM or RUN, flush the FIFO, and clear step_d.
REQ-031 Priority SHALL be rst > stop > reseed > start; start outside IDLE and reseed in IDLE SHALL be ignored.
REQ-032 core_rst SHALL be 1 only in SEED, and core_step SHALL be 0 in IDLE and SEED.
REQ-033 The warm-up counter SHALL be WARM_W bits and SHALL NOT wrap; it decrements to 0 and stops.

Reset
REQ-034 On rst the block SHALL set state=IDLE, core_rst=0, core_step=0, step_d=0, fifo_count=0, pointers=0, rnd_valid=0, rnd_data=0, health_err=0 and busy=0.
REQ-035 An rst mid-operation SHALL discard FIFO contents and SHALL take effect on the next edge.

Configuration
REQ-036 Macro RNG_SCROLL_CTRL_HEALTH_EN SHALL select the stuck-output detector.
REQ-037 With RNG_SCROLL_CTRL_HEALTH_EN defined, 8 consecutive identical pushed words SHALL set health_err (sticky until rst) and force an automatic reseed.
REQ-038 The consecutive-word counter SHALL clear on any differing word or on SEED.
REQ-039 Without the macro, health_err SHALL be tied to 0 and no comparator or counter logic SHALL exist.

Structure
REQ-040 Package rng_scroll_pkg SHALL hold the state enum (IDLE/SEED/WARM/RUN), HEALTH_REPEAT=8, and the default FIFO_DEPTH/WARM_W constants.
REQ-041 The FIFO SHALL be sub-module rng_scroll_fifo, a synchronous show-ahead FIFO with count output.
REQ-042 The FSM, step throttle and health checker SHALL reside in rng_scroll_ctrl.

Verification
REQ-043 start with warm_cycles=5: core_rst for 1 cycle, then exactly 5 core_step cycles in WARM, then RUN, and the first push of x^y^z at the 2nd RUN step edge.
REQ-044 rnd_ready=0 in RUN with FIFO_DEPTH=4: exactly 4 steps, FIFO full, core_step=0 held; a single pop yields one further step and fifo_count returns to 4.
REQ-045 rnd_ready=1 continuously: core_step=1 every RUN cycle and rnd_data equals the model XOR sequence with no gaps or duplicates.
REQ-046 reseed with 3 words queued: FIFO empties next cycle, state=SEED, core_rst=1, and the following words match a fresh-seed model.
REQ-047 stop and reseed asserted in the same RUN cycle: state=IDLE, FIFO retained, core_step=0.
REQ-048 With RNG_SCROLL_CTRL_HEALTH_EN and core inputs forced constant: health_err=1 after the 8th identical push, then an automatic SEED; without the macro, health_err stays 0.
